// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: FSM encoding and datapath widths.
package regfile_write_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Rotating-priority picker: first valid requester at or after i_ptr, wrapping modulo NREQ.
module regfile_write_arbiter_rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] i_valid,
   input  logic [2:0]      i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [2:0]      o_idx,
   output logic            o_any
);

   int w_j;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= NREQ) w_j = w_j - NREQ;
         if (!o_any && i_valid[w_j]) begin
            o_any        = 1'b1;
            o_grant[w_j] = 1'b1;
            o_idx        = 3'(w_j);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port, with bounded port lock and r0 filter.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int LOCK_MAX     = 8,
   parameter int ZERO_DISCARD = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NREQ-1:0]          i_req_valid,
   input  logic [NREQ-1:0]          i_req_lock,
   input  logic [ADDR_W*NREQ-1:0]   i_req_addr,
   input  logic [DATA_W*NREQ-1:0]   i_req_data,
   output logic [NREQ-1:0]          o_req_ready,
   input  logic                     i_wr_stall,
   output logic                     o_wr_en,
   output logic [ADDR_W-1:0]        o_wr_addr,
   output logic [DATA_W-1:0]        o_wr_data,
   output logic [2:0]               o_grant_id,
   output logic                     o_locked
);

   localparam int CW = $clog2(LOCK_MAX + 1);

   arb_state_e          r_state, w_state_nxt;
   logic [2:0]          r_ptr, r_owner;
   logic [CW-1:0]       r_lock_cnt;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic [2:0]          r_grant_id;

   logic                w_accept, w_take, w_force, w_drop;
   logic [NREQ-1:0]     w_elig, w_gnt_oh;
   logic [2:0]          w_gnt_idx;
   logic                w_gnt_any;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_sel_lock;

   function automatic logic [2:0] next_idx(input logic [2:0] idx);
      return (idx == 3'(NREQ - 1)) ? 3'd0 : idx + 3'd1;
   endfunction

   // Nothing is consumed while reset is held, so no beat is lost across reset.
   assign w_accept = (!r_wr_en || !i_wr_stall) && !i_rst;

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NREQ; i++)
         w_elig[i] = i_req_valid[i] && (r_state == ST_ARB || r_owner == 3'(i));
   end

   regfile_write_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
      .i_valid (w_elig),
      .i_ptr   (r_ptr),
      .o_grant (w_gnt_oh),
      .o_idx   (w_gnt_idx),
      .o_any   (w_gnt_any)
   );

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_sel_addr = w_sel_addr | (i_req_addr[ADDR_W*i +: ADDR_W] & {ADDR_W{w_gnt_oh[i]}});
         w_sel_data = w_sel_data | (i_req_data[DATA_W*i +: DATA_W] & {DATA_W{w_gnt_oh[i]}});
      end
   end

   assign w_sel_lock  = |(i_req_lock & w_gnt_oh);
   assign w_take      = w_accept && w_gnt_any;
   assign w_force     = (r_state == ST_LOCKED) && (r_lock_cnt == CW'(LOCK_MAX - 1));
   assign w_drop      = (ZERO_DISCARD != 0) && (w_sel_addr == REG_ZERO);
   assign o_req_ready = w_gnt_oh & {NREQ{w_accept}};

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_ARB) begin
         if (w_take && w_sel_lock) w_state_nxt = ST_LOCKED;
      end else begin
         if (w_force || (w_take && !w_sel_lock)) w_state_nxt = ST_ARB;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_ARB;
         r_ptr      <= '0;
         r_owner    <= '0;
         r_lock_cnt <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_grant_id <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (r_state == ST_ARB && w_take && w_sel_lock) begin
            r_owner    <= w_gnt_idx;
            r_lock_cnt <= '0;
         end else if (r_state == ST_LOCKED) begin
            r_lock_cnt <= r_lock_cnt + CW'(1);
         end

         // While locked only the owner can win, so the pointer always resumes after the owner.
         if (r_state == ST_LOCKED)
            r_ptr <= next_idx(r_owner);
         else if (w_take)
            r_ptr <= next_idx(w_gnt_idx);

         if (w_take) begin
            if (w_drop) begin
               r_wr_en <= 1'b0;
            end else begin
               r_wr_en    <= 1'b1;
               r_wr_addr  <= w_sel_addr;
               r_wr_data  <= w_sel_data;
               r_grant_id <= w_gnt_idx;
            end
         end else if (w_accept) begin
            r_wr_en <= 1'b0;
         end
      end
   end

   assign o_wr_en    = r_wr_en;
   assign o_wr_addr  = r_wr_addr;
   assign o_wr_data  = r_wr_data;
   assign o_grant_id = r_grant_id;
   assign o_locked   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NREQ=4, LOCK_MAX=8, ZERO_DISCARD=1).
module tb_regfile_write_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_valid, req_lock, req_ready;
   logic [15:0]   req_addr;
   logic [127:0]  req_data;
   logic          wr_stall, wr_en, locked;
   logic [3:0]    wr_addr;
   logic [31:0]   wr_data;
   logic [2:0]    grant_id;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(.NREQ(4), .LOCK_MAX(8), .ZERO_DISCARD(1)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_lock  (req_lock),
      .i_req_addr  (req_addr),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .i_wr_stall  (wr_stall),
      .o_wr_en     (wr_en),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .o_grant_id  (grant_id),
      .o_locked    (locked)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic l,
                          input logic [3:0] a, input logic [31:0] d);
      req_valid[i]      = v;
      req_lock[i]       = l;
      req_addr[4*i +: 4]   = a;
      req_data[32*i +: 32] = d;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_lock  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_stall = 1'b0;
      req_valid = 4'b1111; req_lock = '0; req_addr = 16'h4321; req_data = '1;
      settle();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
      tick();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
      checks++; if (grant_id !== 3'd0 || wr_addr !== 4'd0 || wr_data !== 32'd0) begin
         errors++; $display("FAIL reset_regs got id=%0d addr=%0d data=%h exp 0/0/0", grant_id, wr_addr, wr_data);
      end
      rst = 1'b0;
      clear_reqs();
      tick();
   endtask

   task automatic test_rr();
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 4'(i + 1), 32'hD000_0000 + 32'(i));
      for (int k = 0; k < 5; k++) begin
         settle();
         checks++; if (req_ready !== 4'(1 << (k % 4))) begin
            errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << (k % 4)));
         end
         tick();
         checks++; if (wr_en !== 1'b1 || grant_id !== 3'(k % 4) || wr_addr !== 4'(k % 4 + 1)
                       || wr_data !== 32'hD000_0000 + 32'(k % 4)) begin
            errors++; $display("FAIL rr_beat[%0d] got en=%b id=%0d addr=%0d data=%h exp 1/%0d/%0d/%h",
                               k, wr_en, grant_id, wr_addr, wr_data, k % 4, k % 4 + 1, 32'hD000_0000 + 32'(k % 4));
         end
      end
      clear_reqs();
      tick();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rr_idle_wr_en got %b exp 0", wr_en); end
   endtask

   task automatic test_stall();
      set_req(0, 1'b1, 1'b0, 4'd5, 32'hA5A5_0001);
      settle();
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_first_ready got %b exp 0001", req_ready); end
      tick();
      req_valid[0] = 1'b0;
      set_req(1, 1'b1, 1'b0, 4'd7, 32'h1111_0007);
      wr_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0000", k, req_ready); end
         checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_data !== 32'hA5A5_0001) begin
            errors++; $display("FAIL stall_hold[%0d] got en=%b addr=%0d data=%h exp 1/5/a5a50001", k, wr_en, wr_addr, wr_data);
         end
         tick();
      end
      wr_stall = 1'b0;
      settle();
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_release_ready got %b exp 0010", req_ready); end
      tick();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd7 || grant_id !== 3'd1) begin
         errors++; $display("FAIL stall_next_beat got en=%b addr=%0d id=%0d exp 1/7/1", wr_en, wr_addr, grant_id);
      end
      clear_reqs();
      tick();
   endtask

   task automatic test_r0();
      set_req(2, 1'b1, 1'b0, 4'd0, 32'hFFFF_FFFF);
      settle();
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL r0_ready got %b exp 0100", req_ready); end
      tick();
      clear_reqs();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL r0_wr_en got %b exp 0", wr_en); end
      checks++; if (wr_addr !== 4'd7 || wr_data !== 32'h1111_0007 || grant_id !== 3'd1) begin
         errors++; $display("FAIL r0_regs_held got addr=%0d data=%h id=%0d exp 7/11110007/1", wr_addr, wr_data, grant_id);
      end
   endtask

   task automatic test_lock();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(1, 1'b1, 1'b1, 4'd9,  32'hBEEF_0009);
      set_req(3, 1'b1, 1'b0, 4'd10, 32'hCAFE_000A);
      settle();
      checks++; if (req_ready !== 4'b0010 || locked !== 1'b0) begin
         errors++; $display("FAIL lock_entry got ready=%b locked=%b exp 0010/0", req_ready, locked);
      end
      tick();
      for (int m = 0; m < 8; m++) begin
         checks++; if (locked !== 1'b1 || grant_id !== 3'd1 || wr_en !== 1'b1) begin
            errors++; $display("FAIL lock_hold[%0d] got locked=%b id=%0d en=%b exp 1/1/1", m, locked, grant_id, wr_en);
         end
         settle();
         checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_ready[%0d] got %b exp 0010", m, req_ready); end
         tick();
      end
      checks++; if (locked !== 1'b0 || grant_id !== 3'd1) begin
         errors++; $display("FAIL lock_release got locked=%b id=%0d exp 0/1", locked, grant_id);
      end
      settle();
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_other_ready got %b exp 1000", req_ready); end
      tick();
      checks++; if (grant_id !== 3'd3 || wr_addr !== 4'd10 || locked !== 1'b0) begin
         errors++; $display("FAIL lock_other_beat got id=%0d addr=%0d locked=%b exp 3/10/0", grant_id, wr_addr, locked);
      end
   endtask

   task automatic test_midlock_reset();
      settle();
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL relock_ready got %b exp 0010", req_ready); end
      tick();
      checks++; if (locked !== 1'b1 || wr_en !== 1'b1) begin
         errors++; $display("FAIL relock_state got locked=%b en=%b exp 1/1", locked, wr_en);
      end
      rst = 1'b1;
      settle();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b exp 0000", req_ready); end
      tick();
      rst = 1'b0;
      checks++; if (locked !== 1'b0 || wr_en !== 1'b0) begin
         errors++; $display("FAIL midrst_state got locked=%b en=%b exp 0/0", locked, wr_en);
      end
      clear_reqs();
      set_req(0, 1'b1, 1'b0, 4'd2, 32'h0000_0202);
      set_req(3, 1'b1, 1'b0, 4'd3, 32'h0000_0303);
      settle();
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ptr_ready got %b exp 0001", req_ready); end
      tick();
      checks++; if (grant_id !== 3'd0 || wr_addr !== 4'd2 || wr_en !== 1'b1) begin
         errors++; $display("FAIL midrst_beat got id=%0d addr=%0d en=%b exp 0/2/1", grant_id, wr_addr, wr_en);
      end
      clear_reqs();
      tick();
   endtask

   initial begin
      test_reset();
      test_rr();
      test_stall();
      test_r0();
      test_lock();
      test_midlock_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
